// File: rtl/scan_loader.sv
// Byte-wide front end for a serial scan chain: it streams CHAIN_LEN bits in and captures the
// CHAIN_LEN bits that leave the chain, one byte at a time in both directions.
module scan_loader #(
  parameter int unsigned CHAIN_LEN = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       scan_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned NumBytes = CHAIN_LEN / 8;
  localparam int unsigned ByteW    = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam logic [ByteW-1:0] LastByte = ByteW'(NumBytes - 1);
  localparam logic [ByteW-1:0] ByteOne  = ByteW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StEmit,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [2:0]       bit_q, bit_d;
  logic [ByteW-1:0] byte_q, byte_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && !abort) state_d = StLoad;
      StLoad: begin
        if (abort)         state_d = StIdle;
        else if (in_valid) state_d = StShift;
      end
      StShift: begin
        if (abort)              state_d = StIdle;
        else if (bit_q == 3'd7) state_d = StEmit;
      end
      StEmit: begin
        if (abort)          state_d = StIdle;
        else if (out_ready) state_d = (byte_q == LastByte) ? StDone : StLoad;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs are masked by abort so no byte is accepted or consumed as we bail out.
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    scan_enable = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (state_q)
      StIdle:  busy        = 1'b0;
      StLoad:  in_ready    = !abort;
      StShift: scan_enable = 1'b1;
      StEmit:  out_valid   = !abort;
      StDone:  done        = !abort;
      default: busy        = 1'b0;
    endcase
  end

  assign scan_in  = scan_enable & tx_q[0];
  assign out_data = rx_q;

  always_comb begin
    tx_d   = tx_q;
    rx_d   = rx_q;
    bit_d  = bit_q;
    byte_d = byte_q;
    if (abort && (state_q != StIdle)) begin
      bit_d  = '0;
      byte_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            bit_d  = '0;
            byte_d = '0;
          end
        end
        StLoad: if (in_valid) tx_d = in_data;
        StShift: begin
          tx_d  = {1'b0, tx_q[7:1]};
          rx_d  = {scan_out, rx_q[7:1]};
          bit_d = bit_q + 3'd1;
        end
        StEmit: if (out_ready && (byte_q != LastByte)) byte_d = byte_q + ByteOne;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q   <= '0;
      rx_q   <= '0;
      bit_q  <= '0;
      byte_q <= '0;
    end else begin
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      bit_q  <= bit_d;
      byte_q <= byte_d;
    end
  end

endmodule
